// File: rtl/readout_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : psec5_readout_pkg
// Description : Shared defaults, derived widths and FSM state encoding for the
//               channel readout sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package psec5_readout_pkg;

    localparam int c_NUM_CH       = 8;
    localparam int c_WORD_BITS    = 8;
    localparam int c_WORDS_PER_CH = 8;

    localparam int c_CH_W  = (c_NUM_CH    > 1) ? $clog2(c_NUM_CH)    : 1;
    localparam int c_BIT_W = (c_WORD_BITS > 1) ? $clog2(c_WORD_BITS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/readout_sequencer_encoder.sv
`default_nettype none
// ============================================================================
// Module      : lowest_set_encoder
// Description : Combinational priority encoder returning the index of the
//               lowest set bit and a flag telling whether any bit is set.
// Revision    : 1.0 - initial release
// ============================================================================
module lowest_set_encoder #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Scan from the top down so the lowest set bit is the one that sticks.
    always_comb begin
        o_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

    assign o_any = |i_vec;

endmodule
`default_nettype wire

// File: rtl/readout_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : readout_sequencer
// Description : Walks the enabled channels in ascending order; for each one it
//               pulses a load and shifts out WORDS_PER_CH words of WORD_BITS
//               bits, driving the channel select and bit index to the serial
//               output path. Runs entirely in the sclk domain.
// Revision    : 1.0 - initial release
// ============================================================================
module readout_sequencer
    import psec5_readout_pkg::*;
#(
    parameter  int NUM_CH       = c_NUM_CH,
    parameter  int WORD_BITS    = c_WORD_BITS,
    parameter  int WORDS_PER_CH = c_WORDS_PER_CH,
    localparam int c_SEL_W      = (NUM_CH > 1)       ? $clog2(NUM_CH)       : 1,
    localparam int c_CNT_W      = (WORD_BITS > 1)    ? $clog2(WORD_BITS)    : 1,
    localparam int c_WRD_W      = (WORDS_PER_CH > 1) ? $clog2(WORDS_PER_CH) : 1
) (
    input  logic               sclk,
    input  logic               rstn,
    input  logic               inst_readout,
    input  logic               inst_rst,
    input  logic [NUM_CH-1:0]  channel_mask,
    output logic [c_SEL_W-1:0] select_reg,
    output logic               ch_load,
    output logic               ch_shift,
    output logic [c_CNT_W-1:0] bit_cnt,
    output logic               out_valid,
    output logic               busy,
    output logic               done,
    output logic               req_dropped
);

    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(WORD_BITS - 1);
    localparam logic [c_WRD_W-1:0] c_WORD_LAST = c_WRD_W'(WORDS_PER_CH - 1);

    state_t             r_state;
    logic [NUM_CH-1:0]  r_mask;
    logic [c_SEL_W-1:0] r_sel;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [c_WRD_W-1:0] r_word_cnt;
    logic               r_drop;

    state_t             w_state_nxt;
    logic [NUM_CH-1:0]  w_mask_nxt;
    logic [c_SEL_W-1:0] w_sel_nxt;
    logic [c_CNT_W-1:0] w_bit_nxt;
    logic [c_WRD_W-1:0] w_word_nxt;
    logic               w_drop_nxt;

    logic [NUM_CH-1:0]  w_rem_mask;
    logic [c_SEL_W-1:0] w_start_idx;
    logic               w_start_any;
    logic [c_SEL_W-1:0] w_rem_idx;
    logic               w_rem_any;

    // Channels still owed a readout once the current one is finished.
    assign w_rem_mask = r_mask & ~(NUM_CH'(1) << r_sel);

    lowest_set_encoder #(.WIDTH(NUM_CH), .IDX_W(c_SEL_W)) u_start_enc (
        .i_vec (channel_mask),
        .o_idx (w_start_idx),
        .o_any (w_start_any)
    );

    lowest_set_encoder #(.WIDTH(NUM_CH), .IDX_W(c_SEL_W)) u_next_enc (
        .i_vec (w_rem_mask),
        .o_idx (w_rem_idx),
        .o_any (w_rem_any)
    );

    // State and datapath registers; async reset returns everything to idle.
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_mask     <= '0;
            r_sel      <= '0;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
            r_drop     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mask     <= w_mask_nxt;
            r_sel      <= w_sel_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_word_cnt <= w_word_nxt;
            r_drop     <= w_drop_nxt;
        end
    end

    // Next-state, counter updates and state-decoded strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_sel_nxt   = r_sel;
        w_bit_nxt   = r_bit_cnt;
        w_word_nxt  = r_word_cnt;
        w_drop_nxt  = inst_readout && (r_state != ST_IDLE);
        ch_load     = 1'b0;
        ch_shift    = 1'b0;
        out_valid   = 1'b0;
        done        = 1'b0;
        busy        = (r_state != ST_IDLE);

        case (r_state)
            ST_IDLE: begin
                if (inst_readout) begin
                    if (w_start_any) begin
                        w_mask_nxt  = channel_mask;
                        w_sel_nxt   = w_start_idx;
                        w_word_nxt  = '0;
                        w_bit_nxt   = '0;
                        w_state_nxt = ST_LOAD;
                    end else begin
                        // Empty mask: report completion without touching any channel.
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_LOAD: begin
                ch_load     = 1'b1;
                w_bit_nxt   = '0;
                w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                ch_shift  = 1'b1;
                out_valid = 1'b1;
                if (r_bit_cnt == c_BIT_LAST) begin
                    w_bit_nxt = '0;
                    if (r_word_cnt == c_WORD_LAST) begin
                        w_word_nxt = '0;
                        w_mask_nxt = w_rem_mask;
                        if (w_rem_any) begin
                            w_sel_nxt   = w_rem_idx;
                            w_state_nxt = ST_LOAD;
                        end else begin
                            w_state_nxt = ST_DONE;
                        end
                    end else begin
                        w_word_nxt  = r_word_cnt + 1'b1;
                        w_state_nxt = ST_LOAD;
                    end
                end else begin
                    w_bit_nxt = r_bit_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Abort wins over everything, including a same-cycle start request.
        if (inst_rst) begin
            w_state_nxt = ST_IDLE;
            w_mask_nxt  = '0;
            w_sel_nxt   = '0;
            w_bit_nxt   = '0;
            w_word_nxt  = '0;
            w_drop_nxt  = 1'b0;
        end
    end

    assign select_reg  = r_sel;
    assign bit_cnt     = r_bit_cnt;
    assign req_dropped = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_readout_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_readout_sequencer
// Description : Self-checking bench for readout_sequencer. A cycle-by-cycle
//               expected trace is generated from the channel mask and compared
//               with the packed DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_readout_sequencer;

    logic       sclk = 1'b0;
    logic       rstn;
    logic       inst_readout;
    logic       inst_rst;
    logic [7:0] channel_mask;
    logic [2:0] select_reg;
    logic       ch_load;
    logic       ch_shift;
    logic [2:0] bit_cnt;
    logic       out_valid;
    logic       busy;
    logic       done;
    logic       req_dropped;

    int          total = 0;
    int          bad   = 0;
    logic [2:0]  model_sel;
    logic [11:0] exp_q[$];

    always #5 sclk = ~sclk;

    readout_sequencer dut (
        .sclk         (sclk),
        .rstn         (rstn),
        .inst_readout (inst_readout),
        .inst_rst     (inst_rst),
        .channel_mask (channel_mask),
        .select_reg   (select_reg),
        .ch_load      (ch_load),
        .ch_shift     (ch_shift),
        .bit_cnt      (bit_cnt),
        .out_valid    (out_valid),
        .busy         (busy),
        .done         (done),
        .req_dropped  (req_dropped)
    );

    // {sel[2:0], load, shift, bit[2:0], valid, busy, done, dropped}
    function automatic logic [11:0] pk(input int sel, input bit ld, input bit sh,
                                       input int b, input bit v, input bit bz,
                                       input bit dn, input bit dr);
        return {3'(sel), ld, sh, 3'(b), v, bz, dn, dr};
    endfunction

    function automatic logic [11:0] obs();
        return {select_reg, ch_load, ch_shift, bit_cnt, out_valid, busy, done, req_dropped};
    endfunction

    task automatic check(input string tag, input logic [11:0] o, input logic [11:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    // Expected trace for the cycles following the start edge: every enabled
    // channel in ascending order, each word a load then WORD_BITS shifts,
    // then the done cycle and one idle cycle.
    task automatic build(input logic [7:0] m);
        int last;
        exp_q.delete();
        last = int'(model_sel);
        for (int ch = 0; ch < 8; ch++) begin
            if (m[ch]) begin
                for (int w = 0; w < 8; w++) begin
                    exp_q.push_back(pk(ch, 1, 0, 0, 0, 1, 0, 0));
                    for (int b = 0; b < 8; b++)
                        exp_q.push_back(pk(ch, 0, 1, b, 1, 1, 0, 0));
                end
                last = ch;
            end
        end
        exp_q.push_back(pk(last, 0, 0, 0, 0, 1, 1, 0));
        exp_q.push_back(pk(last, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic run(input logic [7:0] m, input int drop_at, input int rst_at,
                       input string tag);
        build(m);
        model_sel = exp_q[exp_q.size() - 1][11:9];
        inst_readout = 1'b1;
        channel_mask = m;
        tick();
        inst_readout = 1'b0;
        for (int i = 1; i <= exp_q.size(); i++) begin
            check($sformatf("%s_c%0d", tag, i), obs(), exp_q[i-1]);
            if (i == rst_at) begin
                inst_rst     = 1'b1;
                inst_readout = 1'b1;
                tick();
                inst_rst     = 1'b0;
                inst_readout = 1'b0;
                check($sformatf("%s_abort", tag), obs(), 12'h000);
                tick();
                check($sformatf("%s_abort_idle", tag), obs(), 12'h000);
                model_sel = 3'd0;
                return;
            end
            if (i == drop_at) begin
                inst_readout = 1'b1;
                channel_mask = 8'h01;
                exp_q[i] = exp_q[i] | 12'h001;
            end else begin
                inst_readout = 1'b0;
            end
            tick();
        end
        inst_readout = 1'b0;
    endtask

    initial begin
        logic [7:0] m;
        rstn         = 1'b0;
        inst_readout = 1'b0;
        inst_rst     = 1'b0;
        channel_mask = 8'h00;
        model_sel    = 3'd0;
        tick();
        tick();
        check("reset", obs(), 12'h000);
        rstn = 1'b1;
        tick();
        check("idle_after_reset", obs(), 12'h000);

        run(8'b0000_0100, 0, 0, "single_ch2");
        run(8'b1000_0011, 0, 0, "ch_0_1_7");
        run(8'h00, 0, 0, "empty_mask");
        run(8'hFF, 20, 0, "drop_req");
        run(8'b0000_1010, 0, 76, "abort_ch3");
        m = 8'($urandom_range(1, 255));
        run(m, 0, 0, "restart");

        // Async reset while in LOAD: outputs must clear before the next edge.
        build(8'h24);
        inst_readout = 1'b1;
        channel_mask = 8'h24;
        tick();
        inst_readout = 1'b0;
        check("arst_load", obs(), exp_q[0]);
        #2 rstn = 1'b0;
        #1 check("arst_async", obs(), 12'h000);
        tick();
        check("arst_held", obs(), 12'h000);
        rstn = 1'b1;
        model_sel = 3'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("arst_idle%0d", i), obs(), 12'h000);
        end

        for (int k = 0; k < 4; k++) begin
            m = 8'($urandom_range(0, 255));
            run(m, 0, 0, $sformatf("rand%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
